// File: rtl/load_sequencer_pkg.sv
// Shared load-request codes and default sizing for the load sequencer and
// the downstream commutation FSM.
package load_sequencer_pkg;

  // Encoding must match the commutation FSM's desired_load input.
  localparam logic [1:0] LD_NUL = 2'b00;
  localparam logic [1:0] LD_A   = 2'b01;
  localparam logic [1:0] LD_B   = 2'b10;
  localparam logic [1:0] LD_C   = 2'b11;

  localparam int LS_CNT_W     = 12;
  localparam int LS_MIN_DWELL = 32;

endpackage

// File: rtl/load_sequencer_dwell_gate.sv
// Output register for the load request: every non-NUL value is held for at
// least MIN_DWELL cycles, except that nul_i forces NUL immediately.
module load_sequencer_dwell_gate
  import load_sequencer_pkg::*;
#(
  parameter int MIN_DWELL = LS_MIN_DWELL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       nul_i,
  output logic [1:0] load_o,
  output logic       hold_o
);

  localparam int              DW_W   = $clog2(MIN_DWELL + 1);
  localparam logic [DW_W-1:0] DW_SAT = DW_W'(MIN_DWELL);
  localparam logic [DW_W-1:0] DW_OK  = DW_W'(MIN_DWELL - 1);

  logic [1:0]      load_q, load_d;
  logic [DW_W-1:0] dwell_q, dwell_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    load_d = load_q;
    hold_o = 1'b0;
    if (nul_i) begin
      load_d = LD_NUL;
    end else if (req_i != load_q) begin
      if (dwell_q >= DW_OK) load_d = req_i;
      else                  hold_o = 1'b1;
    end
  end

  // Parking at NUL saturates the counter so the next phase is never delayed.
  always_comb begin
    if (load_d == LD_NUL)     dwell_d = DW_SAT;
    else if (load_d != load_q) dwell_d = '0;
    else if (dwell_q < DW_SAT) dwell_d = dwell_q + 1'b1;
    else                       dwell_d = dwell_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q  <= LD_NUL;
      dwell_q <= DW_SAT;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      load_q  <= load_d;
      dwell_q <= dwell_d;
    end
  end

  assign load_o = load_q;

endmodule

// File: rtl/load_sequencer.sv
// Carrier counter with double-buffered duties; emits the A/B/C (then C/B/A)
// load request stream, dwell-gated, for the commutation FSM.
module load_sequencer
  import load_sequencer_pkg::*;
#(
  parameter int CNT_W     = LS_CNT_W,
  parameter int MIN_DWELL = LS_MIN_DWELL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty_a,
  input  logic [CNT_W-1:0] duty_b,
  input  logic [CNT_W-1:0] duty_c,
  input  logic             duty_valid,
  output logic [1:0]       desired_load,
  output logic             period_start,
  output logic             duty_ack,
  output logic             dwell_hold,
  output logic             duty_err
);

  logic [CNT_W-1:0] sh_p_q, sh_a_q, sh_b_q, sh_c_q;
  logic [CNT_W-1:0] act_p_q, act_a_q, act_b_q, act_c_q;
  logic             sh_valid_q, sh_new_q, act_valid_q, hold_q;
  logic [CNT_W-1:0] cnt_q;
  logic             parity_q, running_q;
  logic             period_start_q, duty_ack_q, duty_err_q;

  logic [CNT_W+1:0] sh_sum;
  logic             sh_ok, period_end, start, transfer;
  logic [CNT_W:0]   cnt_x, first_end, second_end;
  logic [1:0]       req;

  assign sh_sum     = {2'b00, sh_a_q} + {2'b00, sh_b_q} + {2'b00, sh_c_q};
  assign sh_ok      = (sh_p_q != '0) && (sh_sum == {2'b00, sh_p_q});
  assign cnt_x      = {1'b0, cnt_q};
  assign period_end = running_q && ((cnt_x + 1'b1) >= {1'b0, act_p_q});
  assign start      = en && !running_q && sh_valid_q;
  // A shadow left over from an earlier start is reused on restart, not re-acked.
  assign transfer   = start || (en && period_end && sh_new_q);

  assign first_end  = parity_q ? {1'b0, act_c_q} : {1'b0, act_a_q};
  assign second_end = first_end + {1'b0, act_b_q};

  always_comb begin
    req = LD_NUL;
    if (running_q) begin
      if (hold_q)                  req = desired_load;
      else if (cnt_x < first_end)  req = parity_q ? LD_C : LD_A;
      else if (cnt_x < second_end) req = LD_B;
      else                         req = parity_q ? LD_A : LD_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_p_q         <= '0;
      sh_a_q         <= '0;
      sh_b_q         <= '0;
      sh_c_q         <= '0;
      act_p_q        <= '0;
      act_a_q        <= '0;
      act_b_q        <= '0;
      act_c_q        <= '0;
      sh_valid_q     <= 1'b0;
      sh_new_q       <= 1'b0;
      act_valid_q    <= 1'b0;
      hold_q         <= 1'b0;
      cnt_q          <= '0;
      parity_q       <= 1'b0;
      running_q      <= 1'b0;
      period_start_q <= 1'b0;
      duty_ack_q     <= 1'b0;
      duty_err_q     <= 1'b0;
    end else begin
      period_start_q <= 1'b0;
      duty_ack_q     <= 1'b0;

      if (duty_valid) begin
        sh_p_q     <= period;
        sh_a_q     <= duty_a;
        sh_b_q     <= duty_b;
        sh_c_q     <= duty_c;
        sh_valid_q <= 1'b1;
        sh_new_q   <= 1'b1;
      end else if (transfer) begin
        sh_new_q <= 1'b0;
      end

      if (!en) begin
        running_q <= 1'b0;
        cnt_q     <= '0;
        parity_q  <= 1'b0;
      end else if (start) begin
        running_q      <= 1'b1;
        cnt_q          <= '0;
        parity_q       <= 1'b0;
        period_start_q <= 1'b1;
      end else if (period_end) begin
        cnt_q          <= '0;
        parity_q       <= ~parity_q;
        period_start_q <= 1'b1;
      end else if (running_q) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (transfer) begin
        duty_ack_q <= sh_new_q;
        if (sh_ok) begin
          act_p_q     <= sh_p_q;
          act_a_q     <= sh_a_q;
          act_b_q     <= sh_b_q;
          act_c_q     <= sh_c_q;
          act_valid_q <= 1'b1;
          hold_q      <= 1'b0;
        end else begin
          duty_err_q <= 1'b1;
          if (!act_valid_q) begin
            act_p_q <= sh_p_q;
            hold_q  <= 1'b1;
          end
        end
      end
    end
  end

  load_sequencer_dwell_gate #(
    .MIN_DWELL (MIN_DWELL)
  ) u_dwell_gate (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req),
    .nul_i  (!en),
    .load_o (desired_load),
    .hold_o (dwell_hold)
  );

  assign period_start = period_start_q;
  assign duty_ack     = duty_ack_q;
  assign duty_err     = duty_err_q;

endmodule
